// File: rtl/bit_pair_pkg.sv
// Shared pair encoding for the bit-pair writer and deinterleaver.
// Holds the order-flag values and the decode of one 2-bit beat into {ch1, ch2}.
package bit_pair_pkg;

    typedef logic [1:0] pair_t;

    localparam logic ORDER_CH1_HIGH = 1'b0;
    localparam logic ORDER_CH1_LOW  = 1'b1;

    // Result is {ch1, ch2}.
    function automatic pair_t pair_decode(pair_t pair, logic order);
        return (order == ORDER_CH1_HIGH) ? pair : {pair[0], pair[1]};
    endfunction

endpackage

// File: rtl/bit_pair_deinterleaver_if.sv
// Beat-in / word-pair-out handshake bundle of the deinterleaver.
// master drives beats and out_ready; slave is the deinterleaver itself.
interface bit_pair_deinterleaver_if
    import bit_pair_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    pair_t            in_pair;
    logic             in_order;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data1;
    logic [WIDTH-1:0] out_data2;
    logic [CNT_W-1:0] out_bits;
    logic             out_last;

    modport master (
        output in_valid, in_pair, in_order, in_last, out_ready,
        input  in_ready, out_valid, out_data1, out_data2, out_bits, out_last
    );

    modport slave (
        input  in_valid, in_pair, in_order, in_last, out_ready,
        output in_ready, out_valid, out_data1, out_data2, out_bits, out_last
    );

endinterface

// File: rtl/bit_pair_deinterleaver_acc.sv
// Multi-lane MSB-first shift accumulator sharing one bit counter.
// aligned_o is the word as it would close on the current beat; park keeps it, else the lanes clear.
module bit_pair_acc #(
    parameter int WIDTH = 8,
    parameter int LANES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              beat_i,
    input  logic                              done_i,
    input  logic                              park_i,
    input  logic                              clear_i,
    input  logic [LANES-1:0]                  bits_i,
    output logic [LANES-1:0][WIDTH-1:0]       acc_o,
    output logic [LANES-1:0][WIDTH-1:0]       aligned_o,
    output logic [$clog2(WIDTH+1)-1:0]        cnt_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [LANES-1:0][WIDTH-1:0] acc_q, acc_d, shifted;
    logic [CNT_W-1:0]            cnt_q, cnt_d, shamt;

    // Filled bits sit at the LSB end; closing shifts them up so unfilled LSBs are zero.
    always_comb begin
        shamt = CNT_W'(WIDTH - 1) - cnt_q;
        for (int l = 0; l < LANES; l++) begin
            shifted[l]   = {acc_q[l][WIDTH-2:0], bits_i[l]};
            aligned_o[l] = shifted[l] << shamt;
        end
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (beat_i) begin
            if (done_i) begin
                cnt_d = '0;
                acc_d = park_i ? aligned_o : '0;
            end else begin
                acc_d = shifted;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/bit_pair_deinterleaver.sv
// Splits 2-bit pair beats into two WIDTH-bit channel words; word visible the cycle after its closing beat.
// One hold register plus one parked word; in_ready drops only while a completed word is parked.
module bit_pair_deinterleaver
    import bit_pair_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    bit_pair_deinterleaver_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    pair_t                       lanes;
    logic [1:0][WIDTH-1:0]       acc, aligned;
    logic [CNT_W-1:0]            acc_cnt;
    logic                        accept, complete, drain, take_new, take_pend, park;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data1_q, out_data1_d, out_data2_q, out_data2_d;
    logic [CNT_W-1:0] out_bits_q, out_bits_d, pend_bits_q, pend_bits_d;
    logic             out_last_q, out_last_d, pend_last_q, pend_last_d;
    logic             acc_full_q, acc_full_d, in_ready_q, in_ready_d;

    assign lanes     = pair_decode(bus.in_pair, bus.in_order);
    assign accept    = bus.in_valid && in_ready_q;
    assign complete  = accept && (acc_cnt == CNT_W'(WIDTH - 1) || bus.in_last);
    assign drain     = out_valid_q && bus.out_ready;
    assign take_new  = complete && (!out_valid_q || drain);
    assign take_pend = acc_full_q && drain;
    assign park      = complete && !take_new;

    // Lane 1 carries channel 1, lane 0 channel 2.
    bit_pair_acc #(.WIDTH(WIDTH), .LANES(2)) u_acc (
        .clk       (clk),
        .reset     (reset),
        .beat_i    (accept),
        .done_i    (complete),
        .park_i    (park),
        .clear_i   (take_pend),
        .bits_i    (lanes),
        .acc_o     (acc),
        .aligned_o (aligned),
        .cnt_o     (acc_cnt)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        pend_bits_d = pend_bits_q;
        pend_last_d = pend_last_q;
        acc_full_d  = acc_full_q;
        if (drain) out_valid_d = 1'b0;
        if (take_new) begin
            out_valid_d = 1'b1;
            out_data1_d = aligned[1];
            out_data2_d = aligned[0];
            out_bits_d  = acc_cnt + CNT_W'(1);
            out_last_d  = bus.in_last;
        end else if (take_pend) begin
            out_valid_d = 1'b1;
            out_data1_d = acc[1];
            out_data2_d = acc[0];
            out_bits_d  = pend_bits_q;
            out_last_d  = pend_last_q;
        end
        if (park) begin
            acc_full_d  = 1'b1;
            pend_bits_d = acc_cnt + CNT_W'(1);
            pend_last_d = bus.in_last;
        end else if (take_pend) begin
            acc_full_d  = 1'b0;
        end
        in_ready_d = !acc_full_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data1_q <= '0;
            out_data2_q <= '0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            pend_bits_q <= '0;
            pend_last_q <= 1'b0;
            acc_full_q  <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            pend_bits_q <= pend_bits_d;
            pend_last_q <= pend_last_d;
            acc_full_q  <= acc_full_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data1 = out_data1_q;
    assign bus.out_data2 = out_data2_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_bit_pair_deinterleaver.sv
// Bench for bit_pair_deinterleaver at WIDTH=4: directed word cases plus random beats
// against a queue-of-bits reference model compared every cycle.
module tb_bit_pair_deinterleaver;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bit_pair_deinterleaver_if #(.WIDTH(W)) bus();
    bit_pair_deinterleaver #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        int           bits;
        logic         last;
    } word_t;

    word_t exp_q[$];
    logic  cur1[$];
    logic  cur2[$];
    int    n_vec = 0, n_err = 0, n_words = 0, n_blocked = 0;
    bit    tb_run = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: collect each channel's bits in arrival order, close on W bits or last.
    always @(posedge clk) begin : model
        word_t w;
        logic  c1, c2;
        if (!reset && tb_run) begin
            if (bus.out_valid && bus.out_ready) begin
                n_words++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (bus.in_valid && !bus.in_ready) n_blocked++;
            if (bus.in_valid && bus.in_ready) begin
                c1 = bus.in_order ? bus.in_pair[0] : bus.in_pair[1];
                c2 = bus.in_order ? bus.in_pair[1] : bus.in_pair[0];
                cur1.push_back(c1);
                cur2.push_back(c2);
                if (cur1.size() == W || bus.in_last) begin
                    w.d1 = '0;
                    w.d2 = '0;
                    for (int i = 0; i < cur1.size(); i++) begin
                        w.d1[W-1-i] = cur1[i];
                        w.d2[W-1-i] = cur2[i];
                    end
                    w.bits = cur1.size();
                    w.last = bus.in_last;
                    exp_q.push_back(w);
                    cur1.delete();
                    cur2.delete();
                end
            end
        end
    end

    // At most one word in hold plus one parked: a second queued word means in_ready is low.
    always @(negedge clk) begin
        if (!reset && tb_run) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
            if (exp_q.size() > 0) begin
                chk("out_data1", 32'(bus.out_data1), 32'(exp_q[0].d1));
                chk("out_data2", 32'(bus.out_data2), 32'(exp_q[0].d2));
                chk("out_bits", 32'(bus.out_bits), 32'(exp_q[0].bits));
                chk("out_last", 32'(bus.out_last), 32'(exp_q[0].last));
            end
        end
    end

    task automatic send(input logic [1:0] p, input logic o, input logic l);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_pair  = p;
        bus.in_order = o;
        bus.in_last  = l;
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        cur1.delete();
        cur2.delete();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data1", 32'(bus.out_data1), 32'd0);
        chk("rst_out_data2", 32'(bus.out_data2), 32'd0);
        chk("rst_out_bits", 32'(bus.out_bits), 32'd0);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        tb_run = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drain_all();
        bus.out_ready = 1'b1;
        idle(6);
        chk("drained_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int w0, b0;
        bus.in_valid  = 1'b0;
        bus.in_pair   = 2'b00;
        bus.in_order  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Full word, order 0.
        send(2'b10, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        chk("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
        send(2'b11, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_d1", 32'(bus.out_data1), 32'b1101);
        chk("t1_d2", 32'(bus.out_data2), 32'b0011);
        chk("t1_bits", 32'(bus.out_bits), 32'd4);
        chk("t1_last", 32'(bus.out_last), 32'd0);
        drain_all();

        // Same beats, order 1.
        send(2'b10, 1'b1, 1'b0);
        send(2'b10, 1'b1, 1'b0);
        send(2'b01, 1'b1, 1'b0);
        send(2'b11, 1'b1, 1'b0);
        chk("t2_d1", 32'(bus.out_data1), 32'b0011);
        chk("t2_d2", 32'(bus.out_data2), 32'b1101);
        drain_all();

        // Partial flush after two beats.
        send(2'b11, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b1);
        chk("t4_d1", 32'(bus.out_data1), 32'b1000);
        chk("t4_d2", 32'(bus.out_data2), 32'b1100);
        chk("t4_bits", 32'(bus.out_bits), 32'd2);
        chk("t4_last", 32'(bus.out_last), 32'd1);
        drain_all();

        // Last on the very first beat of a word.
        send(2'b10, 1'b0, 1'b1);
        chk("first_last_bits", 32'(bus.out_bits), 32'd1);
        chk("first_last_d1", 32'(bus.out_data1), 32'b1000);
        drain_all();

        // Backpressure: two words fill hold and park, ninth beat waits.
        send(2'b10, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b11, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b00, 1'b0, 1'b0);
        chk("t3_stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_hold_d1", 32'(bus.out_data1), 32'b1101);
        fork
            send(2'b11, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clk);
                chk("t3_still_stalled", 32'(bus.in_ready), 32'd0);
                chk("t3_hold_stable", 32'(bus.out_data1), 32'b1101);
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
                chk("t3_w2_d1", 32'(bus.out_data1), 32'b0010);
                chk("t3_w2_d2", 32'(bus.out_data2), 32'b1100);
                chk("t3_released", 32'(bus.in_ready), 32'd1);
            end
        join
        send(2'b00, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        chk("t3_restall", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_w3_d1", 32'(bus.out_data1), 32'b1010);
        chk("t3_w3_d2", 32'(bus.out_data2), 32'b1001);
        drain_all();

        // Streaming with out_ready tied high.
        bus.out_ready = 1'b1;
        w0 = n_words;
        b0 = n_blocked;
        for (int i = 0; i < 12; i++)
            send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
        idle(3);
        chk("stream_words", 32'(n_words - w0), 32'd3);
        chk("stream_no_block", 32'(n_blocked - b0), 32'd0);
        bus.out_ready = 1'b0;

        // Reset mid-word, then mid-stall, then a clean word.
        send(2'b11, 1'b0, 1'b0);
        send(2'b11, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) send(2'b11, 1'b0, 1'b0);
        chk("t6_stalled", 32'(bus.in_ready), 32'd0);
        do_reset();
        bus.out_ready = 1'b1;
        send(2'b10, 1'b0, 1'b0);
        send(2'b10, 1'b0, 1'b0);
        send(2'b01, 1'b0, 1'b0);
        send(2'b11, 1'b0, 1'b0);
        chk("t6_clean_d1", 32'(bus.out_data1), 32'b1101);
        chk("t6_clean_d2", 32'(bus.out_data2), 32'b0011);
        chk("t6_clean_bits", 32'(bus.out_bits), 32'd4);
        drain_all();

        // Random traffic with random consumer stalls.
        begin
            bit done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 400; i++) begin
                        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
                        send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 5) == 0));
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        bus.out_ready = ($urandom_range(0, 2) != 0);
                        @(negedge clk);
                    end
                end
            join
        end
        drain_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
